// File: rtl/insn_decode_stage.sv
// Decode stage: splits an instruction into opcode/util/reg/immediate, latency 1, full throughput; stalls only via in_ready = !out_valid || out_ready.
// Define INSN_DECODE_PREFIX_EN to enable immediate-extension prefixes (PREFIX_OP loads a high nibble for the next instruction).
module insn_decode_stage #(
    parameter int          INSN_W    = 8,
    parameter int          REG_W     = 3,
    parameter int          IMM_W     = 8,
    parameter logic [3:0]  PREFIX_OP = 4'hB
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INSN_W-1:0] insn,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        opcode_out,
    output logic              util_out,
    output logic [REG_W-1:0]  reg_out,
    output logic [IMM_W-1:0]  imm_out,
    output logic              imm_ext_out
);

    logic [3:0]       op_in;
    logic             is_const;
    logic             is_pfx;
    logic             accept;
    logic [IMM_W-1:0] imm_d;

    assign op_in    = insn[INSN_W-1 -: 4];
    assign is_const = op_in[3] & op_in[2] & (op_in[1] | op_in[0]);
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;

`ifdef INSN_DECODE_PREFIX_EN
    typedef enum logic { NORMAL, PREFIXED } state_t;

    state_t     state;
    logic [3:0] pfx;
    logic       ext_d;
    logic       ext_q;

    assign is_pfx = (op_in == PREFIX_OP);

    always_comb begin
        imm_d = '0;
        ext_d = 1'b0;
        if (is_const) begin
            imm_d = IMM_W'(2);
        end else if (state == PREFIXED) begin
            imm_d[7:4] = pfx;
            imm_d[3:0] = insn[3:0];
            ext_d      = 1'b1;
        end else begin
            imm_d[3:0] = insn[3:0];
        end
    end

    // Any accepted non-prefix consumes the held nibble, constant opcodes included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= NORMAL;
            pfx   <= 4'h0;
            ext_q <= 1'b0;
        end else if (flush) begin
            state <= NORMAL;
            pfx   <= 4'h0;
        end else if (accept) begin
            if (is_pfx) begin
                state <= PREFIXED;
                pfx   <= insn[3:0];
            end else begin
                state <= NORMAL;
                pfx   <= 4'h0;
                ext_q <= ext_d;
            end
        end
    end

    assign imm_ext_out = ext_q;
`else
    assign is_pfx = 1'b0;

    always_comb begin
        imm_d = '0;
        if (is_const) begin
            imm_d = IMM_W'(2);
        end else begin
            imm_d[3:0] = insn[3:0];
        end
    end

    assign imm_ext_out = 1'b0;
`endif

    // Payload only changes on an accepted non-prefix, so it holds under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            opcode_out <= 4'h0;
            util_out   <= 1'b0;
            reg_out    <= '0;
            imm_out    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept && !is_pfx) begin
            out_valid  <= 1'b1;
            opcode_out <= op_in;
            util_out   <= insn[REG_W];
            reg_out    <= insn[REG_W-1:0];
            imm_out    <= imm_d;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_insn_decode_stage.sv
// Directed-vector bench for insn_decode_stage; prefix vectors follow INSN_DECODE_PREFIX_EN.
module tb_insn_decode_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] insn;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] opcode_out;
    logic       util_out;
    logic [2:0] reg_out;
    logic [7:0] imm_out;
    logic       imm_ext_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    insn_decode_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .insn        (insn),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .opcode_out  (opcode_out),
        .util_out    (util_out),
        .reg_out     (reg_out),
        .imm_out     (imm_out),
        .imm_ext_out (imm_ext_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present one instruction for one clock edge, then sample 1 time unit after the edge.
    task automatic send(input logic [7:0] v);
        in_valid = 1'b1;
        insn     = v;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] op, input logic u,
                           input logic [2:0] r, input logic [7:0] imm, input logic ext);
        chk({tag, ".vld"}, 32'(out_valid), 32'd1);
        chk({tag, ".op"},  32'(opcode_out), 32'(op));
        chk({tag, ".util"}, 32'(util_out), 32'(u));
        chk({tag, ".reg"}, 32'(reg_out), 32'(r));
        chk({tag, ".imm"}, 32'(imm_out), 32'(imm));
        chk({tag, ".ext"}, 32'(imm_ext_out), 32'(ext));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".vld"}, 32'(out_valid), 32'd0);
        chk({tag, ".op"},  32'(opcode_out), 32'd0);
        chk({tag, ".util"}, 32'(util_out), 32'd0);
        chk({tag, ".reg"}, 32'(reg_out), 32'd0);
        chk({tag, ".imm"}, 32'(imm_out), 32'd0);
        chk({tag, ".ext"}, 32'(imm_ext_out), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        insn      = 8'h00;
        flush     = 1'b0;
        out_ready = 1'b1;
        #2;
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk_zero("rst");
        idle();
        idle();
        rst_n = 1'b1;
        idle();

        // plain decode and constant-immediate opcode
        send(8'h2D);
        chk_out("plain", 4'h2, 1'b1, 3'd5, 8'h0D, 1'b0);
        send(8'hE7);
        chk_out("const", 4'hE, 1'b0, 3'd7, 8'h02, 1'b0);
        send(8'hDA);
        chk_out("constD", 4'hD, 1'b1, 3'd2, 8'h02, 1'b0);
        send(8'hC5);
        chk_out("lowC", 4'hC, 1'b0, 3'd5, 8'h05, 1'b0);
        idle();
        chk("drain.vld", 32'(out_valid), 32'd0);

`ifdef INSN_DECODE_PREFIX_EN
        // prefix, idle gap, then low-nibble instruction gets extended
        send(8'hB9);
        chk("pfx.novld", 32'(out_valid), 32'd0);
        idle();
        chk("pfx.gap", 32'(out_valid), 32'd0);
        send(8'h34);
        chk_out("pfx.ext", 4'h3, 1'b0, 3'd4, 8'h94, 1'b1);
        idle();
        chk("pfx.single", 32'(out_valid), 32'd0);
        // constant opcode after prefix drops the nibble
        send(8'hB9);
        send(8'hE7);
        chk_out("pfx.const", 4'hE, 1'b0, 3'd7, 8'h02, 1'b0);
        send(8'h34);
        chk_out("pfx.dropped", 4'h3, 1'b0, 3'd4, 8'h04, 1'b0);
        // second prefix overwrites the first
        send(8'hB9);
        send(8'hB2);
        chk("pfx2.novld", 32'(out_valid), 32'd0);
        send(8'h34);
        chk_out("pfx2.ext", 4'h3, 1'b0, 3'd4, 8'h24, 1'b1);
`else
        send(8'hB9);
        chk_out("nopfx", 4'hB, 1'b1, 3'd1, 8'h09, 1'b0);
`endif
        idle();

        // backpressure: hold 15, offer 26
        out_ready = 1'b0;
        send(8'h15);
        chk_out("bp.first", 4'h1, 1'b0, 3'd5, 8'h05, 1'b0);
        in_valid = 1'b1;
        insn     = 8'h26;
        #1;
        chk("bp.in_ready0", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk_out("bp.hold", 4'h1, 1'b0, 3'd5, 8'h05, 1'b0);
        out_ready = 1'b1;
        #1;
        chk("bp.in_ready1", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk_out("bp.next", 4'h2, 1'b0, 3'd6, 8'h06, 1'b0);
        idle();

        // flush: B3, flush with a discarded instruction, then 41
        send(8'hB3);
`ifndef INSN_DECODE_PREFIX_EN
        chk_out("fl.b3", 4'hB, 1'b0, 3'd3, 8'h03, 1'b0);
`endif
        flush = 1'b1;
        send(8'h5A);
        flush = 1'b0;
        chk("fl.vld", 32'(out_valid), 32'd0);
        send(8'h41);
        chk_out("fl.after", 4'h4, 1'b0, 3'd1, 8'h01, 1'b0);
        idle();

        // flush also drops a stalled output
        out_ready = 1'b0;
        send(8'h15);
        flush = 1'b1;
        idle();
        flush = 1'b0;
        chk("fl.stall", 32'(out_valid), 32'd0);
        out_ready = 1'b1;

        // reset while output held under backpressure
        out_ready = 1'b0;
        send(8'h2D);
        chk("mrst.pre", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_zero("mrst");
        chk("mrst.in_ready", 32'(in_ready), 32'd1);
        idle();
        rst_n = 1'b1;
        out_ready = 1'b1;
        idle();
        chk("mrst.quiet", 32'(out_valid), 32'd0);
        send(8'h41);
        chk_out("mrst.after", 4'h4, 1'b0, 3'd1, 8'h01, 1'b0);

`ifdef INSN_DECODE_PREFIX_EN
        // reset while PREFIXED clears the held nibble
        send(8'hB9);
        rst_n = 1'b0;
        #1;
        chk_zero("prst");
        idle();
        rst_n = 1'b1;
        idle();
        send(8'h41);
        chk_out("prst.after", 4'h4, 1'b0, 3'd1, 8'h01, 1'b0);
`endif
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
